// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of an external combinational ALU: issues queued operands,
// captures each result with overflow/negative flags and holds it until consumed.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [3:0]               cmd_sel,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_sel,
    input  logic [WIDTH-1:0]         alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [3:0]               res_sel,
    output logic                     res_err,
    output logic                     res_neg,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       sel;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    cmd_t             head;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q;

    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [3:0]       alu_sel_q;
    logic             res_valid_q, res_err_q, res_neg_q;
    logic [WIDTH-1:0] res_data_q;
    logic [3:0]       res_sel_q;

    logic             push, pop;
    logic [WIDTH-1:0] exec_data;
    logic             exec_err, exec_neg;

    assign cmd_ready = !rst && (count_q < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // Pop only from a non-empty queue; an empty IDLE queue never bypasses to the ALU.
    assign pop       = (count_q != '0) &&
                       ((state_q == IDLE) || ((state_q == HOLD) && res_ready));
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Undefined opcodes (sel[3]) ignore the ALU and report an error with zero data.
    always_comb begin
        exec_data = alu_out;
        exec_err  = 1'b0;
        exec_neg  = 1'b0;
        if (alu_sel_q[3]) begin
            exec_data = '0;
            exec_err  = 1'b1;
        end else begin
            exec_err = ((alu_sel_q == 4'b0000) || (alu_sel_q == 4'b0010)) && alu_out[WIDTH-1];
            exec_neg = (alu_sel_q == 4'b0001) && alu_out[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
            res_err_q   <= 1'b0;
            res_neg_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                alu_a_q   <= head.a;
                alu_b_q   <= head.b;
                alu_sel_q <= head.sel;
            end
            case (state_q)
                IDLE: begin
                    if (pop) state_q <= EXEC;
                end
                EXEC: begin
                    res_valid_q <= 1'b1;
                    res_data_q  <= exec_data;
                    res_sel_q   <= alu_sel_q;
                    res_err_q   <= exec_err;
                    res_neg_q   <= exec_neg;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= pop ? EXEC : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_sel   = res_sel_q;
    assign res_err   = res_err_q;
    assign res_neg   = res_neg_q;
    assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: a behavioural ALU closes the loop, a scoreboard checks
// every result in order, and hand sequences cover latency, stalls and reset.
module tb_alu_cmd_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [8:0] cmd_a = '0, cmd_b = '0;
    logic [3:0] cmd_sel = '0;
    logic [8:0] alu_a, alu_b;
    logic [3:0] alu_sel;
    logic [8:0] alu_out;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [8:0] res_data;
    logic [3:0] res_sel;
    logic       res_err, res_neg;
    logic [2:0] count;

    typedef struct packed {
        logic [8:0] data;
        logic [3:0] sel;
        logic       err;
        logic       neg;
    } res_t;

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic [3:0] sel;
        logic [8:0] data;
        logic       err;
        logic       neg;
    } vec_t;

    int   total_cnt = 0, pass_cnt = 0;
    int   mon_total = 0, mon_pass = 0;
    int   cyc = 0;
    res_t sb[$];
    int   hs_cyc[$];
    res_t drv_exp = '0;

    alu_cmd_queue #(.DEPTH(4), .WIDTH(9)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_sel(res_sel), .res_err(res_err), .res_neg(res_neg),
        .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] tb_alu(input logic [8:0] a, input logic [8:0] b, input logic [3:0] s);
        case (s[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << 1;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return ~a;
            default: return b;
        endcase
    endfunction

    always_comb alu_out = tb_alu(alu_a, alu_b, alu_sel);

    function automatic res_t exp_of(input logic [8:0] a, input logic [8:0] b, input logic [3:0] s);
        res_t       r;
        logic [8:0] v;
        v = tb_alu(a, b, s);
        r.sel = s;
        if (s[3]) begin
            r.data = '0; r.err = 1'b1; r.neg = 1'b0;
        end else begin
            r.data = v;
            r.err  = ((s == 4'd0) || (s == 4'd2)) && v[8];
            r.neg  = (s == 4'd1) && v[8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Scoreboard: accepted commands push their expectation, handshaken results pop it.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (cmd_valid && cmd_ready) sb.push_back(drv_exp);
            if (res_valid && res_ready) begin
                res_t got, req;
                got = '{data: res_data, sel: res_sel, err: res_err, neg: res_neg};
                hs_cyc.push_back(cyc);
                mon_total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_result: got data=0x%0h sel=0x%0h, required none", res_data, res_sel);
                end else begin
                    req = sb.pop_front();
                    if (got === req) begin
                        mon_pass++;
                        $display("result data=0x%03h sel=0x%0h err=%0b neg=%0b", res_data, res_sel, res_err, res_neg);
                    end else begin
                        $display("FAIL result: got data=0x%0h sel=0x%0h err=%0b neg=%0b, required data=0x%0h sel=0x%0h err=%0b neg=%0b",
                                 got.data, got.sel, got.err, got.neg, req.data, req.sel, req.err, req.neg);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the command.
    task automatic push_cmd(input logic [8:0] a, input logic [8:0] b, input logic [3:0] s, input res_t e);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_sel = s; drv_exp = e; cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                check("push_timeout", 32'd0, 32'd1);
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(sb.size() == 0 && !res_valid && count == 0)) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                check("drain_timeout", 32'(sb.size()), 32'd0);
                return;
            end
        end
    endtask

    initial begin
        vec_t vecs[12];
        int   hs_mark;
        bit   rnd_done;

        vecs[0]  = '{9'h001, 9'h0FF, 4'b0000, 9'h100, 1'b1, 1'b0};
        vecs[1]  = '{9'h070, 9'h00B, 4'b0001, 9'h065, 1'b0, 1'b0};
        vecs[2]  = '{9'h00B, 9'h070, 4'b0001, 9'h19B, 1'b0, 1'b1};
        vecs[3]  = '{9'h0EE, 9'h0A0, 4'b1001, 9'h000, 1'b1, 1'b0};
        vecs[4]  = '{9'h010, 9'h020, 4'b0000, 9'h030, 1'b0, 1'b0};
        vecs[5]  = '{9'h0C0, 9'h000, 4'b0010, 9'h180, 1'b1, 1'b0};
        vecs[6]  = '{9'h012, 9'h000, 4'b0010, 9'h024, 1'b0, 1'b0};
        vecs[7]  = '{9'h1F0, 9'h100, 4'b0011, 9'h100, 1'b0, 1'b0};
        vecs[8]  = '{9'h055, 9'h055, 4'b0001, 9'h000, 1'b0, 1'b0};
        vecs[9]  = '{9'h1AB, 9'h0CD, 4'b1111, 9'h000, 1'b1, 1'b0};
        vecs[10] = '{9'h1FF, 9'h001, 4'b0000, 9'h000, 1'b0, 1'b0};
        vecs[11] = '{9'h100, 9'h000, 4'b0001, 9'h100, 1'b0, 1'b1};

        // Reset state
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        check("rst_res", 32'({res_data, res_sel, res_err, res_neg}), 32'd0);

        // Release, then push on the very first edge: Add overflow, 2-edge latency
        @(posedge clk); #1;
        rst = 1'b0; res_ready = 1'b1;
        cmd_a = 9'h001; cmd_b = 9'h0FF; cmd_sel = 4'b0000;
        drv_exp = '{data: 9'h100, sel: 4'h0, err: 1'b1, neg: 1'b0};
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("first_push_count", 32'(count), 32'd1);
        check("lat_edge0_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_edge1_valid", 32'(res_valid), 32'd0);
        check("issue_alu_a", 32'(alu_a), 32'h001);
        @(posedge clk); #1;
        check("lat_edge2_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        check("after_pop_valid", 32'(res_valid), 32'd0);
        wait_drain();

        // Table-driven vectors with the consumer always ready
        foreach (vecs[i]) begin
            push_cmd(vecs[i].a, vecs[i].b, vecs[i].sel,
                     '{data: vecs[i].data, sel: vecs[i].sel, err: vecs[i].err, neg: vecs[i].neg});
        end
        wait_drain();
        check("alu_hold_last", 32'({alu_a, alu_b, alu_sel}), 32'({9'h100, 9'h000, 4'b0001}));

        // Stall: five commands -> one held, four queued, sixth refused
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(9'(16 * i + 3), 9'(i + 1), 4'(i % 3), exp_of(9'(16 * i + 3), 9'(i + 1), 4'(i % 3)));
        end
        check("stall_count", 32'(count), 32'd4);
        check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        check("stall_valid", 32'(res_valid), 32'd1);
        cmd_a = 9'h1EE; cmd_b = 9'h011; cmd_sel = 4'b0000;
        drv_exp = exp_of(9'h1EE, 9'h011, 4'b0000);
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("sixth_refused_count", 32'(count), 32'd4);
        check("hold_stable", 32'({res_valid, res_data, res_sel}), 32'({1'b1, exp_of(9'h003, 9'h001, 4'd0).data, 4'd0}));
        hs_mark = hs_cyc.size();
        res_ready = 1'b1;
        wait_drain();
        check("stall_results", 32'(hs_cyc.size() - hs_mark), 32'd5);
        for (int i = hs_mark + 1; i < hs_cyc.size(); i++) begin
            check("result_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
        end

        // Simultaneous push and pop at count 2
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cmd(9'(40 + i), 9'(7 * i), 4'd1, exp_of(9'(40 + i), 9'(7 * i), 4'd1));
        end
        check("pp_pre_count", 32'(count), 32'd2);
        res_ready = 1'b1;
        push_cmd(9'h0AA, 9'h055, 4'd5, exp_of(9'h0AA, 9'h055, 4'd5));
        check("pp_count", 32'(count), 32'd2);
        wait_drain();

        // Asynchronous reset while holding with three queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(9'(i + 1), 9'(i + 2), 4'd0, exp_of(9'(i + 1), 9'(i + 2), 4'd0));
        end
        check("prerst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(res_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", 32'({res_valid, count}), 32'd0);
        end

        // Random commands with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [8:0] ra, rb;
                    logic [3:0] rs;
                    ra = 9'($urandom_range(0, 511));
                    rb = 9'($urandom_range(0, 511));
                    rs = 4'($urandom_range(0, 15));
                    push_cmd(ra, rb, rs, exp_of(ra, rb, rs));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        wait_drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt + mon_pass, total_cnt + mon_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
